// File: rtl/stopwatch_display_driver.sv
// Multiplexed 4-digit 7-segment driver for the stopwatch: shows a per-frame snapshot
// of MM.SS and blanks the display in alternating groups of frames while paused.
module stopwatch_display_driver #(
  parameter int REFRESH_DIV    = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    ST_PAUSED  = 2'b10;
  localparam logic [3:0]    DIG_DASH   = 4'hF;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [7:0]    mm_q, mm_d;
  logic [5:0]    ss_q, ss_d;
  logic [1:0]    st_q, st_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic          load_pending_q, load_pending_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          presc_tc, frame_tick, load;
  logic [7:0]    src_mm;
  logic [5:0]    src_ss;
  logic [3:0]    mm_tens, mm_ones, ss_tens, ss_ones, dig;
  logic [6:0]    seg_raw;
  logic [3:0]    an_raw;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'h3F;
      4'd1:    enc7 = 7'h06;
      4'd2:    enc7 = 7'h5B;
      4'd3:    enc7 = 7'h4F;
      4'd4:    enc7 = 7'h66;
      4'd5:    enc7 = 7'h6D;
      4'd6:    enc7 = 7'h7D;
      4'd7:    enc7 = 7'h07;
      4'd8:    enc7 = 7'h7F;
      4'd9:    enc7 = 7'h6F;
      default: enc7 = 7'h40;
    endcase
  endfunction

  always_comb begin
    presc_d        = presc_q;
    digit_d        = digit_q;
    mm_d           = mm_q;
    ss_d           = ss_q;
    st_d           = st_q;
    blink_cnt_d    = blink_cnt_q;
    blink_ph_d     = blink_ph_q;
    load_pending_d = 1'b0;

    presc_tc   = (presc_q == PRESC_LAST);
    frame_tick = presc_tc && (digit_q == 2'd3);
    load       = load_pending_q || frame_tick;

    if (presc_tc) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // A frame only counts toward the blink period if it was itself shown as paused.
    if (load) begin
      mm_d = minutes;
      ss_d = seconds;
      st_d = status;
      if (load_pending_q || status != ST_PAUSED || st_q != ST_PAUSED) begin
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // The very first cycle after reset shows the values being captured, not stale zeros.
    src_mm  = load_pending_q ? minutes : mm_q;
    src_ss  = load_pending_q ? seconds : ss_q;
    mm_tens = 4'(src_mm / 8'd10);
    mm_ones = 4'(src_mm % 8'd10);
    ss_tens = 4'(src_ss / 6'd10);
    ss_ones = 4'(src_ss % 6'd10);

    case (digit_q)
      2'd0:    dig = (src_ss > 6'd59) ? DIG_DASH : ss_ones;
      2'd1:    dig = (src_ss > 6'd59) ? DIG_DASH : ss_tens;
      2'd2:    dig = (src_mm > 8'd99) ? DIG_DASH : mm_ones;
      default: dig = (src_mm > 8'd99) ? DIG_DASH : mm_tens;
    endcase

    seg_raw = enc7(dig);
    an_raw  = blink_ph_q ? 4'b0000 : (4'b0001 << digit_q);
    seg_d   = seg_raw ^ {7{SEG_ACTIVE_LOW}};
    dp_d    = (digit_q == 2'd2) ^ SEG_ACTIVE_LOW;
    an_d    = an_raw ^ {4{AN_ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      digit_q        <= '0;
      mm_q           <= '0;
      ss_q           <= '0;
      st_q           <= '0;
      blink_cnt_q    <= '0;
      blink_ph_q     <= 1'b0;
      load_pending_q <= 1'b1;
      seg_q          <= {7{SEG_ACTIVE_LOW}};
      dp_q           <= SEG_ACTIVE_LOW;
      an_q           <= {4{AN_ACTIVE_LOW}};
    end else begin
      presc_q        <= presc_d;
      digit_q        <= digit_d;
      mm_q           <= mm_d;
      ss_q           <= ss_d;
      st_q           <= st_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_ph_q     <= blink_ph_d;
      load_pending_q <= load_pending_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      an_q           <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Bench for stopwatch_display_driver: per-cycle expected {an,seg,dp} words are queued
// per frame and compared on the falling edge.
module tb_stopwatch_display_driver;

  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_FRAMES = 2;
  localparam logic [11:0] RESET_WORD = {4'b1111, 7'h7F, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] minutes = 8'd0;
  logic [5:0] seconds = 6'd0;
  logic [1:0] status = 2'b00;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  stopwatch_display_driver #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_FRAMES(BLINK_FRAMES),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .minutes(minutes),
    .seconds(seconds),
    .status(status),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  // Queue one frame of expected outputs; c0..c3 are active-high codes for digits 0..3.
  task automatic push_frame(input logic [6:0] c0, input logic [6:0] c1,
                            input logic [6:0] c2, input logic [6:0] c3, input bit lit);
    logic [6:0] code;
    logic [3:0] one_hot;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0: code = c0;
        1: code = c1;
        2: code = c2;
        default: code = c3;
      endcase
      one_hot = 4'b0001;
      one_hot = one_hot << d;
      for (int r = 0; r < REFRESH_DIV; r++)
        exp_q.push_back({(lit ? ~one_hot : 4'b1111), ~code, (d == 2) ? 1'b0 : 1'b1});
    end
  endtask

  // Compare n cycles; after the compare at index apply_at, drive the new inputs.
  task automatic check_cycles(input string name, input int n, input logic [7:0] nm,
                              input logic [5:0] ns, input logic [1:0] nst, input int apply_at);
    logic [11:0] exp;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s cyc %0d: no expected entry queued", name, j);
      end else begin
        exp = exp_q.pop_front();
        if ({an, seg, dp} !== exp) begin
          miscompares++;
          $display("FAIL %s cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                   name, j, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
        end
      end
      if (j == apply_at) begin
        minutes = nm;
        seconds = ns;
        status  = nst;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic [6:0] c3, input bit lit,
                             input logic [7:0] nm, input logic [5:0] ns, input logic [1:0] nst,
                             input int apply_at);
    push_frame(c0, c1, c2, c3, lit);
    check_cycles(name, 4 * REFRESH_DIV, nm, ns, nst, apply_at);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(RESET_WORD);
    check_cycles("reset_hold", 3, 8'd0, 6'd0, 2'b00, -1);
    rst = 1'b0;
    check_frame("reset_frame00", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1, 8'd12, 6'd34, 2'b01, 2);
  endtask

  task automatic test_digits();
    check_frame("digits_1234", 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1, 8'd12, 6'd35, 2'b01, 5);
  endtask

  task automatic test_snapshot();
    check_frame("snapshot_1235", 7'h6D, 7'h4F, 7'h5B, 7'h06, 1'b1, 8'd12, 6'd35, 2'b10, 3);
  endtask

  task automatic test_blink();
    bit lit_pat[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 7; f++)
      check_frame($sformatf("blink_f%0d", f), 7'h6D, 7'h4F, 7'h5B, 7'h06, lit_pat[f],
                  8'd12, 6'd35, 2'b01, (f == 6) ? 7 : -1);
    check_frame("resume_lit", 7'h6D, 7'h4F, 7'h5B, 7'h06, 1'b1, 8'd150, 6'd60, 2'b01, 0);
  endtask

  task automatic test_dash_and_max();
    check_frame("dash", 7'h40, 7'h40, 7'h40, 7'h40, 1'b1, 8'd99, 6'd59, 2'b11, 14);
    check_frame("max_9959", 7'h6F, 7'h6D, 7'h6F, 7'h6F, 1'b1, 8'd45, 6'd6, 2'b01, 1);
  endtask

  task automatic test_mid_reset();
    push_frame(7'h7D, 7'h3F, 7'h6D, 7'h66, 1'b1);
    check_cycles("pre_reset_4506", 2 * REFRESH_DIV + 1, 8'd45, 6'd6, 2'b01, -1);
    exp_q.delete();
    rst     = 1'b1;
    minutes = 8'd8;
    seconds = 6'd42;
    status  = 2'b10;
    exp_q.push_back(RESET_WORD);
    check_cycles("mid_reset", 1, 8'd8, 6'd42, 2'b10, -1);
    rst = 1'b0;
    check_frame("reload_f0", 7'h5B, 7'h66, 7'h7F, 7'h3F, 1'b1, 8'd8, 6'd42, 2'b10, -1);
    check_frame("reload_f1", 7'h5B, 7'h66, 7'h7F, 7'h3F, 1'b1, 8'd8, 6'd42, 2'b10, -1);
    check_frame("reload_f2", 7'h5B, 7'h66, 7'h7F, 7'h3F, 1'b0, 8'd8, 6'd42, 2'b10, -1);
  endtask

  initial begin
    test_reset();
    test_digits();
    test_snapshot();
    test_blink();
    test_dash_and_max();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
